// File: rtl/blur_arb_pkg.sv
// Shared widths, default kernel size and FSM encoding for the blur job arbiter.
// Pure declarations: no latency, no backpressure.
package blur_arb_pkg;

    localparam int RGB_W          = 25;
    localparam int RES_W          = 32;
    localparam int KERNEL_PIX_DEF = 9;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/blur_job_arbiter_rr_pick.sv
// Round-robin picker: lowest set req at or above ptr, else lowest set req overall.
// Purely combinational, zero latency; no handshake, so no backpressure.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    always_comb begin
        grant   = '0;
        any_req = |req;
        // Descending scans leave the lowest hit; the second scan overrides with the
        // lowest hit at or above ptr whenever one exists.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                grant = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j] && (IDX_W'(j) >= ptr)) begin
                grant = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/blur_job_arbiter.sv
// Job-granular round-robin sharing of one blur accelerator; 1-cycle grant, beats pass combinationally.
// Backpressure: owner sees accelerator busy in SEND, everyone else is stalled; results wait on owner's busy.
module blur_job_arbiter
    import blur_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int KERNEL_PIX = KERNEL_PIX_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_vld,
    input  logic [NUM_REQ*RGB_W-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]         o_req_busy,
    output logic [NUM_REQ-1:0]         o_resp_vld,
    output logic [RES_W-1:0]           o_resp_data,
    input  logic [NUM_REQ-1:0]         i_resp_busy,
    output logic                       o_acc_rgb_vld,
    output logic [RGB_W-1:0]           o_acc_rgb_data,
    input  logic                       i_acc_rgb_busy,
    input  logic                       i_acc_result_vld,
    input  logic [RES_W-1:0]           i_acc_result_data,
    output logic                       o_acc_result_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_owner,
    output logic                       o_active,
    output logic [CNT_W-1:0]           o_job_count
);

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam int                BEAT_W    = $clog2(KERNEL_PIX + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(KERNEL_PIX - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [BEAT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [RES_W-1:0]   result_reg, result_nxt;
    logic [CNT_W-1:0]   job_count, job_count_nxt;
    logic [IDX_W-1:0]   pick;
    logic               any_req;
    logic [RGB_W-1:0]   beat [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign beat[g] = i_req_data[g*RGB_W +: RGB_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (i_req_vld),
        .ptr     (rr_ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            beat_cnt   <= '0;
            result_reg <= '0;
            job_count  <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            owner      <= owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
            result_reg <= result_nxt;
            job_count  <= job_count_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        rr_ptr_nxt        = rr_ptr;
        owner_nxt         = owner;
        beat_cnt_nxt      = beat_cnt;
        result_nxt        = result_reg;
        job_count_nxt     = job_count;
        o_req_busy        = '1;
        o_resp_vld        = '0;
        o_acc_rgb_vld     = 1'b0;
        o_acc_result_busy = 1'b1;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_nxt    = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                o_acc_rgb_vld     = i_req_vld[owner];
                o_req_busy[owner] = i_acc_rgb_busy;
                if (i_req_vld[owner] && !i_acc_rgb_busy) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                o_acc_result_busy = 1'b0;
                if (i_acc_result_vld) begin
                    result_nxt = i_acc_result_data;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                o_resp_vld[owner] = 1'b1;
                if (!i_resp_busy[owner]) begin
                    // The finisher drops to lowest priority for the next pick.
                    rr_ptr_nxt    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    job_count_nxt = job_count + 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_acc_rgb_data = beat[owner];
    assign o_resp_data    = result_reg;
    assign o_owner        = owner;
    assign o_active       = (state != IDLE);
    assign o_job_count    = job_count;

endmodule

// File: doc/blur_job_arbiter.md
Name: blur_job_arbiter

Overview:
- Shares one Gaussian_Blur accelerator instance among NUM_REQ requesting cores.
- A job is KERNEL_PIX rgb beats, 3x3 by default, which produce exactly one 32-bit result.
- Ownership is job-granular and round-robin: the arbiter locks the winner until its result has been delivered.
- Sits between the core-side request ports and the accelerator's i_rgb_*/o_result_* interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- KERNEL_PIX, 9, rgb beats per job.
- CNT_W, 16, width of the completed-job counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req_vld  in  NUM_REQ  per-requester rgb beat valid.
- i_req_data  in  NUM_REQ*25  per-requester beat; requester k owns slice [25k+24:25k].
- o_req_busy  out  NUM_REQ  per-requester stall.
- o_resp_vld  out  NUM_REQ  result valid, one-hot to the job owner.
- o_resp_data  out  32  result data, shared by all requesters.
- i_resp_busy  in  NUM_REQ  per-requester result stall.
- o_acc_rgb_vld  out  1  to accelerator i_rgb_vld.
- o_acc_rgb_data  out  25  to accelerator i_rgb_data.
- i_acc_rgb_busy  in  1  from accelerator i_rgb_busy.
- i_acc_result_vld  in  1  from accelerator o_result_vld.
- i_acc_result_data  in  32  from accelerator o_result_data.
- o_acc_result_busy  out  1  to accelerator o_result_busy.
- o_owner  out  clog2(NUM_REQ)  current or last owner index.
- o_active  out  1  high in any state other than IDLE.
- o_job_count  out  CNT_W  completed jobs; wraps modulo 2^CNT_W.

Behaviour:
- Handshake on every interface: a transfer occurs on a rising i_clk edge where vld=1 and busy=0. A sender holds vld and data stable until the transfer. Bit 24 of rgb data passes through unmodified and is not interpreted.
- Reset (i_rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, result_reg=0, o_job_count=0.
  - o_req_busy all 1, o_resp_vld all 0, o_acc_rgb_vld=0, o_acc_result_busy=1, o_active=0.
  - Mid-job reset abandons the job with no response. The accelerator shares i_rst, so its internal state is flushed in the same cycle.
- IDLE:
  - All o_req_busy=1.
  - If any i_req_vld is set, the arbiter picks the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - It registers owner, clears beat_cnt and moves to SEND. Grant latency is 1 cycle and no beat is consumed in IDLE.
- SEND:
  - o_acc_rgb_vld = i_req_vld[owner]; o_acc_rgb_data = owner's slice; o_req_busy[owner] = i_acc_rgb_busy. Every other o_req_busy = 1.
  - Each transfer increments beat_cnt.
  - The transfer with beat_cnt = KERNEL_PIX-1 moves the FSM to WAIT. o_req_busy[owner] is 1 from the next cycle.
  - The mux is combinational, so a beat can pass in the same cycle it arrives.
- WAIT:
  - o_acc_result_busy=0.
  - On i_acc_result_vld, the FSM captures i_acc_result_data into result_reg and moves to RESP.
  - o_acc_result_busy=1 in every state except WAIT. A premature result is therefore held off by the accelerator and never dropped.
- RESP:
  - o_resp_vld[owner]=1 and o_resp_data=result_reg.
  - On transfer (i_resp_busy[owner]=0), the FSM does the following:
    - rr_ptr = (owner+1) mod NUM_REQ;
    - o_job_count increments;
    - state returns to IDLE.
  - o_resp_data holds result_reg in all states.
- Simultaneous requests: exactly one winner per job. A requester that has just finished has lowest priority for the next pick. With all NUM_REQ requesters active, every requester is served once per NUM_REQ jobs.
- A requester deasserting i_req_vld mid-job stalls SEND indefinitely; there is no timeout. Only reset recovers.
- Minimum job turnaround is 1 (IDLE) + KERNEL_PIX (SEND) + accelerator latency + 1 (RESP) cycles.

Decomposition:
- Package blur_arb_pkg holds the following:
  - RGB_W=25 and RES_W=32;
  - the default KERNEL_PIX;
  - the state enum {IDLE, SEND, WAIT, RESP}.
- Sub-module rr_pick: a combinational round-robin priority picker with inputs req[NUM_REQ] and ptr. Its outputs are a grant index and any_req.

Test Plan:
- Basic job (NUM_REQ=4): requester 2 sends beats 0x0000001..0x0000009 with no stalls; the accelerator model returns 0x12345678.
  - The accelerator receives the beats in order.
  - o_resp_vld=4'b0100 with data 0x12345678.
  - o_job_count=1 and o_owner=2.
- Contention: requesters 0, 1 and 3 all hold vld from reset release. Grant order must be 0, 1, 3, 0, 1, 3, and no beat may be interleaved between jobs.
- Accelerator backpressure: i_acc_rgb_busy is toggled every other cycle during SEND.
  - o_req_busy[owner] mirrors it exactly.
  - Exactly 9 beats are accepted and the FSM enters WAIT.
- Response stall: i_resp_busy[owner]=1 for 5 cycles in RESP.
  - o_resp_vld and o_resp_data are held constant.
  - No new grant is issued until the transfer, and o_job_count increments only once.
- Reset mid-job: i_rst is asserted after 4 beats. Next cycle:
  - state=IDLE, all o_req_busy=1, o_acc_rgb_vld=0, o_job_count=0.
  - A new 9-beat job then completes normally.
- Counter wrap (CNT_W=4): run 17 jobs; o_job_count must read 1.
